// File: rtl/jb_aes_pkg.sv
// Shared types and defaults for the JB AES stream adapter.
package jb_aes_pkg;
  localparam int BLOCK_WIDTH_DEF = 128;
  localparam int BYTE_WIDTH_DEF  = 8;
  localparam int BYTES_PER_BLOCK = BLOCK_WIDTH_DEF / BYTE_WIDTH_DEF;

  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} jb_stream_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jb_aes_byte_shifter.sv
// Parallel-load, byte-shift register with a symbol counter; used to pack and unpack blocks.
module jb_aes_byte_shifter
  import jb_aes_pkg::*;
#(
  parameter int W     = BLOCK_WIDTH_DEF,
  parameter int B     = BYTE_WIDTH_DEF,
  parameter int OUT_W = W
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             load_i,
  input  logic [W-1:0]     load_data_i,
  input  logic             shift_i,
  input  logic [B-1:0]     byte_i,
  input  logic             clr_i,
  output logic [OUT_W-1:0] data_o,
  output logic             last_o
);
  localparam int N  = W / B;
  localparam int CW = cnt_w(N);

  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i)       data_d = load_data_i;
    else if (shift_i) data_d = {data_q[W-B-1:0], byte_i};
    if (load_i || clr_i) cnt_d = '0;
    else if (shift_i)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q[W-1 -: OUT_W];
  assign last_o = (cnt_q == CW'(N-1));
endmodule

// File: rtl/jb_aes_stream_ctrl.sv
// Byte-stream front end for one JB AES core: pack block, pulse nStart, await nDone fall, drain result.
module jb_aes_stream_ctrl
  import jb_aes_pkg::*;
#(
  parameter int BLOCK_WIDTH    = BLOCK_WIDTH_DEF,
  parameter int BYTE_WIDTH     = BYTE_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic [BLOCK_WIDTH-1:0] key,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BYTE_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BYTE_WIDTH-1:0]  out_data,
  output logic                   core_nStart,
  input  logic                   core_nDone,
  output logic [BLOCK_WIDTH-1:0] core_key,
  output logic [BLOCK_WIDTH-1:0] core_blockin,
  input  logic [BLOCK_WIDTH-1:0] core_blockout,
  output logic                   busy,
  output logic                   err
);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  jb_stream_state_t       state_q;
  logic                   in_ready_q, out_valid_q, nstart_q, busy_q, err_q, ndone_q;
  logic [TW-1:0]          timer_q;
  logic [BLOCK_WIDTH-1:0] key_q;

  logic in_hs, out_hs, pk_last, up_last, done_evt, tmo, up_load;

  assign in_hs    = in_valid & in_ready_q;
  assign out_hs   = out_valid_q & out_ready;
  // Only a high->low transition counts, so a level left low by a previous block is ignored.
  assign done_evt = ndone_q & ~core_nDone;
  assign tmo      = (TIMEOUT_CYCLES != 0) && (timer_q == TLAST);
  assign up_load  = (state_q == S_WAIT) && done_evt;

  jb_aes_byte_shifter #(.W(BLOCK_WIDTH), .B(BYTE_WIDTH), .OUT_W(BLOCK_WIDTH)) u_pack (
    .clk         (clk),
    .nRst        (nRst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (in_hs),
    .byte_i      (in_data),
    .clr_i       (in_hs & pk_last),
    .data_o      (core_blockin),
    .last_o      (pk_last)
  );

  jb_aes_byte_shifter #(.W(BLOCK_WIDTH), .B(BYTE_WIDTH), .OUT_W(BYTE_WIDTH)) u_unpack (
    .clk         (clk),
    .nRst        (nRst),
    .load_i      (up_load),
    .load_data_i (core_blockout),
    .shift_i     (out_hs),
    .byte_i      ('0),
    .clr_i       (out_hs & up_last),
    .data_o      (out_data),
    .last_o      (up_last)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      nstart_q    <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ndone_q     <= 1'b1;
      timer_q     <= '0;
      key_q       <= '0;
    end else begin
      ndone_q <= core_nDone;
      case (state_q)
        S_FILL: if (in_hs && pk_last) begin
          state_q    <= S_START;
          in_ready_q <= 1'b0;
          nstart_q   <= 1'b0;
          busy_q     <= 1'b1;
          key_q      <= key;
        end
        S_START: begin
          state_q  <= S_WAIT;
          nstart_q <= 1'b1;
          timer_q  <= '0;
        end
        S_WAIT: begin
          if (done_evt) begin
            state_q     <= S_DRAIN;
            out_valid_q <= 1'b1;
          end else if (tmo) begin
            state_q    <= S_FILL;
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DRAIN: if (out_hs && up_last) begin
          state_q     <= S_FILL;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign core_nStart = nstart_q;
  assign core_key    = key_q;
  assign busy        = busy_q;
  assign err         = err_q;
endmodule

// File: tb/tb_jb_aes_stream_ctrl.sv
// Randomized bench for jb_aes_stream_ctrl with a behavioural core and byte-queue reference.
module tb_jb_aes_stream_ctrl;
  localparam int BW  = 128;
  localparam int YW  = 8;
  localparam int NB  = BW / YW;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          nRst;
  logic [BW-1:0] key;
  logic          in_valid, in_ready;
  logic [YW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [YW-1:0] out_data;
  logic          core_nStart, core_nDone;
  logic [BW-1:0] core_key, core_blockin, core_blockout;
  logic          busy, err;

  int checks = 0;
  int errors = 0;
  int nst_seen = 0;
  int nst_exp  = 0;

  logic [7:0]    ib [NB];
  logic [BW-1:0] cur_key, cur_resp;

  always #5 clk = ~clk;

  jb_aes_stream_ctrl #(.BLOCK_WIDTH(BW), .BYTE_WIDTH(YW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .key           (key),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .core_nStart   (core_nStart),
    .core_nDone    (core_nDone),
    .core_key      (core_key),
    .core_blockin  (core_blockin),
    .core_blockout (core_blockout),
    .busy          (busy),
    .err           (err)
  );

  always @(negedge clk)
    if (nRst === 1'b1 && core_nStart === 1'b0) nst_seen <= nst_seen + 1;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected packed block: bytes in arrival order, first byte most significant.
  function automatic logic [BW-1:0] pack_ref();
    logic [BW-1:0] r = '0;
    for (int i = 0; i < NB; i++) r = r * 256 + BW'(ib[i]);
    return r;
  endfunction

  function automatic logic [YW-1:0] out_ref(input int k);
    return YW'(cur_resp >> (YW * (NB - 1 - k)));
  endfunction

  task automatic set_seq();
    cur_key  = BW'(27);
    cur_resp = '0;
    for (int i = 0; i < NB; i++) begin
      ib[i]    = 8'(i);
      cur_resp = cur_resp * 256 + BW'(8'hA5 - i);
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < NB; i++) ib[i] = 8'($urandom);
    cur_key  = rand_blk();
    cur_resp = rand_blk();
  endtask

  task automatic do_reset(input string tag);
    #2 nRst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; core_nDone = 1'b1;
    #1;
    chk({tag, "_in_ready"},  BW'(in_ready),    BW'(1));
    chk({tag, "_out_valid"}, BW'(out_valid),   BW'(0));
    chk({tag, "_nstart"},    BW'(core_nStart), BW'(1));
    chk({tag, "_busy"},      BW'(busy),        BW'(0));
    chk({tag, "_err"},       BW'(err),         BW'(0));
    chk({tag, "_out_data"},  BW'(out_data),    BW'(0));
    chk({tag, "_core_key"},  core_key,         BW'(0));
    chk({tag, "_blockin"},   core_blockin,     BW'(0));
    @(negedge clk);
    nRst = 1'b1;
  endtask

  // Ends at the negedge of the first WAIT cycle.
  task automatic feed();
    for (int i = 0; i < NB; i++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        in_valid = 1'b0; key = rand_blk();
        @(negedge clk);
      end
      if (i == 0) chk("in_ready_fill", BW'(in_ready), BW'(1));
      in_valid = 1'b1;
      in_data  = ib[i];
      key      = (i == NB - 1) ? cur_key : rand_blk();
      @(negedge clk);
    end
    in_valid = 1'b0;
    key      = rand_blk();
    nst_exp++;
    chk("nstart_lo",      BW'(core_nStart), BW'(0));
    chk("in_ready_start", BW'(in_ready),    BW'(0));
    chk("busy_start",     BW'(busy),        BW'(1));
    chk("blockin",        core_blockin,     pack_ref());
    chk("key_latch",      core_key,         cur_key);
    @(negedge clk);
    chk("nstart_hi",      BW'(core_nStart), BW'(1));
    chk("key_hold",       core_key,         cur_key);
  endtask

  task automatic core_resp(input bit stale, input bit hold_low, input int lat);
    if (stale) begin
      repeat (5) @(negedge clk);
      chk("stale_ignored", BW'(out_valid), BW'(0));
      core_nDone = 1'b1;
      repeat (10) @(negedge clk);
    end else begin
      repeat (lat - 1) @(negedge clk);
    end
    chk("oval_pre",     BW'(out_valid), BW'(0));
    chk("blockin_hold", core_blockin,   pack_ref());
    chk("in_ready_wait", BW'(in_ready), BW'(0));
    core_nDone    = 1'b0;
    core_blockout = cur_resp;
    @(negedge clk);
    core_blockout = rand_blk();
    chk("oval_post", BW'(out_valid), BW'(1));
    if (!hold_low) core_nDone = 1'b1;
  endtask

  task automatic drain(input int stop);
    int k = 0;
    int n = 0;
    while (k < stop && n < 2000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      chk("oval_hold", BW'(out_valid), BW'(1));
      if (out_ready) begin
        chk($sformatf("out_byte%0d", k), BW'(out_data), BW'(out_ref(k)));
        k++;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("drain_count", BW'(k), BW'(stop));
    if (stop == NB) begin
      chk("oval_end",     BW'(out_valid), BW'(0));
      chk("busy_end",     BW'(busy),      BW'(0));
      chk("in_ready_end", BW'(in_ready),  BW'(1));
    end
  endtask

  task automatic run_block(input bit stale, input bit hold_low, input int lat);
    feed();
    core_resp(stale, hold_low, lat);
    drain(NB);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRst = 1'b0; in_valid = 1'b0; in_data = '0; key = '0;
    out_ready = 1'b0; core_nDone = 1'b1; core_blockout = '0;
    repeat (2) @(negedge clk);
    do_reset("rst_init");

    set_seq();
    run_block(1'b0, 1'b0, 20);

    for (int r = 0; r < 3; r++) begin
      set_rand();
      run_block(1'b0, 1'b0, $urandom_range(1, 40));
    end

    set_rand();
    run_block(1'b0, 1'b1, 15);
    set_rand();
    run_block(1'b1, 1'b0, 0);

    set_rand();
    feed();
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_busy_last", BW'(busy), BW'(1));
    chk("tmo_err_last",  BW'(err),  BW'(0));
    @(negedge clk);
    chk("tmo_err",      BW'(err),       BW'(1));
    chk("tmo_busy",     BW'(busy),      BW'(0));
    chk("tmo_in_ready", BW'(in_ready),  BW'(1));
    chk("tmo_oval",     BW'(out_valid), BW'(0));
    set_rand();
    run_block(1'b0, 1'b0, 12);
    chk("err_sticky", BW'(err), BW'(1));

    set_rand();
    feed();
    repeat (5) @(negedge clk);
    do_reset("rst_wait");
    set_seq();
    run_block(1'b0, 1'b0, 20);

    set_rand();
    feed();
    core_resp(1'b0, 1'b0, 8);
    drain(7);
    do_reset("rst_drain");
    set_seq();
    run_block(1'b0, 1'b0, 20);

    repeat (3) @(negedge clk);
    chk("nstart_count", BW'(nst_seen), BW'(nst_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
